// File: rtl/udp_rxbuf_sink.sv
// Receive-buffer sink for a UDP engine: stores one packet, presents its header
// and payload to the user, and hands the buffer back once the user acknowledges.
module udp_rxbuf_sink #(
  parameter int AWIDTH            = 6,
  parameter int MAX_PAYLOAD_BYTES = 248
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] rxbuf_addr,
  input  logic              rxbuf_ce,
  input  logic              rxbuf_we,
  input  logic [31:0]       rxbuf_wdata,
  input  logic              rxbuf_cpu_grant,
  output logic              rxbuf_cpu_rel,
  output logic              pkt_valid,
  output logic [31:0]       pkt_src_ip,
  output logic [15:0]       pkt_src_port,
  output logic [15:0]       pkt_len,
  output logic              pkt_trunc,
  input  logic              pkt_ack,
  input  logic [AWIDTH-2:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic [15:0]       pkt_count,
  output logic [7:0]        err_count
);

  localparam int          DEPTH   = 2 ** AWIDTH;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_BYTES);

  typedef enum logic [1:0] {FILL, HOLD, REL, DRAIN} state_t;

  state_t state, state_nxt;
  logic   rel_c;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       hdr0, hdr1;
  logic [31:0]       hdr0_nxt, hdr1_nxt;
  logic [31:0]       rd_data_p1;
  logic [AWIDTH-1:0] rd_word_addr;
  logic              wr_q, wr_fill, wr_err, latch_hdr;

  function automatic logic [15:0] clip_len(input logic [15:0] raw);
    return (raw > MAX_LEN) ? MAX_LEN : raw;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wr_q      = rxbuf_ce & rxbuf_we;
  assign wr_fill   = wr_q && (state == FILL);
  assign wr_err    = wr_q && (state != FILL);
  assign latch_hdr = (state == FILL) && rxbuf_cpu_grant;

  // Header bypass: a header write in the grant cycle must be seen by the latch.
  always_comb begin
    hdr0_nxt = hdr0;
    hdr1_nxt = hdr1;
    if (wr_fill && (rxbuf_addr == AWIDTH'(0))) hdr0_nxt = rxbuf_wdata;
    if (wr_fill && (rxbuf_addr == AWIDTH'(1))) hdr1_nxt = rxbuf_wdata;
  end

  always_ff @(posedge clk) begin
    if (wr_fill) mem[rxbuf_addr] <= rxbuf_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr0 <= '0;
      hdr1 <= '0;
    end else begin
      hdr0 <= hdr0_nxt;
      hdr1 <= hdr1_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rel_c     = 1'b0;
    case (state)
      FILL:  if (rxbuf_cpu_grant) state_nxt = HOLD;
      HOLD:  if (pkt_ack && pkt_valid) state_nxt = REL;
      REL: begin
        rel_c     = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: if (!rxbuf_cpu_grant) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  assign rxbuf_cpu_rel = rel_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_valid    <= 1'b0;
      pkt_src_ip   <= '0;
      pkt_src_port <= '0;
      pkt_len      <= '0;
      pkt_trunc    <= 1'b0;
    end else if (latch_hdr) begin
      pkt_valid    <= 1'b1;
      pkt_src_ip   <= hdr0_nxt;
      pkt_src_port <= hdr1_nxt[15:0];
      pkt_len      <= clip_len(hdr1_nxt[31:16]);
      pkt_trunc    <= (hdr1_nxt[31:16] > MAX_LEN);
    end else if ((state == HOLD) && pkt_ack && pkt_valid) begin
      pkt_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (state == REL) pkt_count <= pkt_count + 16'd1;
      if (wr_err)       err_count <= sat_inc8(err_count);
    end
  end

  // Payload read port: one register stage, index offset past the two header words.
  assign rd_word_addr = {1'b0, rd_addr} + AWIDTH'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_p1 <= '0;
    else        rd_data_p1 <= mem[rd_word_addr];
  end

  assign rd_data = rd_data_p1;

endmodule

// File: tb/tb_udp_rxbuf_sink.sv
// Directed bench for udp_rxbuf_sink: packet hold/release, truncation,
// protected-buffer errors, same-cycle header write and mid-hold reset.
module tb_udp_rxbuf_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rxbuf_addr;
  logic        rxbuf_ce, rxbuf_we;
  logic [31:0] rxbuf_wdata;
  logic        rxbuf_cpu_grant;
  logic        rxbuf_cpu_rel;
  logic        pkt_valid;
  logic [31:0] pkt_src_ip;
  logic [15:0] pkt_src_port, pkt_len;
  logic        pkt_trunc;
  logic        pkt_ack;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;
  int rel_pulses = 0;
  int rel_seen;

  udp_rxbuf_sink dut (
    .clk(clk), .rst_n(rst_n),
    .rxbuf_addr(rxbuf_addr), .rxbuf_ce(rxbuf_ce), .rxbuf_we(rxbuf_we),
    .rxbuf_wdata(rxbuf_wdata), .rxbuf_cpu_grant(rxbuf_cpu_grant),
    .rxbuf_cpu_rel(rxbuf_cpu_rel), .pkt_valid(pkt_valid),
    .pkt_src_ip(pkt_src_ip), .pkt_src_port(pkt_src_port), .pkt_len(pkt_len),
    .pkt_trunc(pkt_trunc), .pkt_ack(pkt_ack), .rd_addr(rd_addr),
    .rd_data(rd_data), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rxbuf_cpu_rel === 1'b1) rel_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    rxbuf_addr = a; rxbuf_wdata = d; rxbuf_ce = 1'b1; rxbuf_we = 1'b1;
    tick();
    rxbuf_ce = 1'b0; rxbuf_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, pkt_valid, 0);
    check({tag, "_rel"},   rxbuf_cpu_rel, 0);
    check({tag, "_ip"},    pkt_src_ip, 0);
    check({tag, "_port"},  pkt_src_port, 0);
    check({tag, "_len"},   pkt_len, 0);
    check({tag, "_trunc"}, pkt_trunc, 0);
    check({tag, "_pcnt"},  pkt_count, 0);
    check({tag, "_ecnt"},  err_count, 0);
    check({tag, "_rdata"}, rd_data, 0);
  endtask

  initial begin
    rst_n = 1'b0; rxbuf_addr = '0; rxbuf_ce = 1'b0; rxbuf_we = 1'b0;
    rxbuf_wdata = '0; rxbuf_cpu_grant = 1'b0; pkt_ack = 1'b0; rd_addr = '0;

    // reset state
    #3;
    check_all_zero("reset");
    #9 rst_n = 1'b1;
    tick();

    // basic packet
    wr(6'd0, 32'hC0A8010A);
    wr(6'd1, 32'h000704D2);
    wr(6'd2, 32'h626F6F66);
    wr(6'd3, 32'h000A7261);
    rxbuf_cpu_grant = 1'b1;
    tick();
    check("basic_valid", pkt_valid, 1);
    check("basic_ip", pkt_src_ip, 32'hC0A8010A);
    check("basic_port", pkt_src_port, 16'd1234);
    check("basic_len", pkt_len, 16'd7);
    check("basic_trunc", pkt_trunc, 0);
    rd_addr = 5'd1;
    tick();
    check("basic_rd1", rd_data, 32'h000A7261);
    rd_addr = 5'd0;
    tick();
    check("basic_rd0", rd_data, 32'h626F6F66);

    // protected buffer
    wr(6'd2, 32'hDEADBEEF);
    check("prot_err1", err_count, 8'd1);
    tick();
    check("prot_rd0", rd_data, 32'h626F6F66);
    check("prot_hold_valid", pkt_valid, 1);

    // release handshake
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    check("rel_valid_drop", pkt_valid, 0);
    check("rel_pulse_hi", rxbuf_cpu_rel, 1);
    tick();
    check("rel_pulse_lo", rxbuf_cpu_rel, 0);
    check("rel_pcnt", pkt_count, 16'd1);
    rel_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rxbuf_cpu_rel === 1'b1) rel_seen++;
    end
    check("rel_no_second", rel_seen, 0);
    check("rel_total", rel_pulses, 1);
    check("rel_hdr_stable", pkt_src_ip, 32'hC0A8010A);
    rxbuf_cpu_grant = 1'b0;
    tick();
    wr(6'd2, 32'h11111111);
    check("fill_no_err", err_count, 8'd1);
    tick();
    check("fill_rd0", rd_data, 32'h11111111);

    // truncation and saturation
    wr(6'd0, 32'h0A000001);
    wr(6'd1, 32'h012C0035);
    rxbuf_cpu_grant = 1'b1;
    tick();
    check("trunc_len", pkt_len, 16'd248);
    check("trunc_flag", pkt_trunc, 1);
    check("trunc_port", pkt_src_port, 16'd53);
    wr(6'd2, 32'h22222222);
    check("sat_err2", err_count, 8'd2);
    for (int i = 0; i < 300; i++) wr(6'd2, 32'h33333333);
    check("sat_err255", err_count, 8'd255);
    tick();
    check("sat_rd0", rd_data, 32'h11111111);
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    rxbuf_cpu_grant = 1'b0;
    tick();
    check("trunc_pcnt", pkt_count, 16'd2);
    tick();

    // same-cycle write and grant
    wr(6'd0, 32'h0A0000FE);
    rxbuf_addr = 6'd1; rxbuf_wdata = 32'h00140050;
    rxbuf_ce = 1'b1; rxbuf_we = 1'b1; rxbuf_cpu_grant = 1'b1;
    tick();
    rxbuf_ce = 1'b0; rxbuf_we = 1'b0;
    check("same_len", pkt_len, 16'd20);
    check("same_port", pkt_src_port, 16'd80);
    check("same_trunc", pkt_trunc, 0);
    check("same_err", err_count, 8'd255);

    // reset mid-hold
    rel_seen = rel_pulses;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    rxbuf_cpu_grant = 1'b0;
    tick();
    check("midrst_no_rel", rel_pulses, rel_seen);
    #3 rst_n = 1'b1;
    tick();
    wr(6'd0, 32'h01020304);
    wr(6'd1, 32'h00100007);
    rxbuf_cpu_grant = 1'b1;
    tick();
    check("post_valid", pkt_valid, 1);
    check("post_ip", pkt_src_ip, 32'h01020304);
    check("post_len", pkt_len, 16'd16);
    check("post_port", pkt_src_port, 16'd7);
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    check("post_rel", rxbuf_cpu_rel, 1);
    tick();
    check("post_pcnt", pkt_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
